// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit holding the HI/LO pair.
// An accepted op captures its operands, keeps busy high for a fixed number
// of cycles, then commits HI/LO in one step. mthi/mtlo write directly
// while idle. Reads of HI/LO are combinational.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDOp,
  input  logic        MDWE,
  input  logic        MDAddrOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] MDOut
);

  localparam int MAXC   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW_RAW = $clog2(MAXC + 1);
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt, w_cnt_load;
  logic           r_busy;
  logic [2:0]     r_op;
  logic [31:0]    r_a, r_b;
  logic [31:0]    r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic           w_op_valid, w_commit;

  // Arithmetic datapath (operates on captured operands only)
  logic [63:0]        w_umul;
  logic signed [63:0] w_sa64, w_sb64, w_smul;
  logic [31:0]        w_b_safe, w_uq, w_ur;
  logic signed [31:0] w_sa, w_sb, w_sq, w_sr;
  logic               w_div_ovf, w_div_zero;

  assign w_op_valid = (MDOp >= OP_MULTU) && (MDOp <= OP_DIV);
  assign start      = reset && (r_state == S_IDLE) && w_op_valid;
  assign busy       = r_busy;
  assign MDOut      = MDAddrOp ? r_hi : r_lo;
  assign w_cnt_load = ((MDOp == OP_MULTU) || (MDOp == OP_MULT)) ? CW'(MULT_CYCLES)
                                                              : CW'(DIV_CYCLES);

  // Multiply and divide results; divisor is forced nonzero so the quotient
  // is always defined, the zero case is filtered at commit instead.
  always_comb begin
    w_umul     = {32'b0, r_a} * {32'b0, r_b};
    w_sa64     = {{32{r_a[31]}}, r_a};
    w_sb64     = {{32{r_b[31]}}, r_b};
    w_smul     = w_sa64 * w_sb64;
    w_div_zero = (r_b == 32'd0);
    w_b_safe   = w_div_zero ? 32'd1 : r_b;
    w_uq       = r_a / w_b_safe;
    w_ur       = r_a % w_b_safe;
    w_sa       = $signed(r_a);
    w_sb       = $signed(w_b_safe);
    // most-negative / -1 overflows 32 bits; pin it to the wrapped quotient
    w_div_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    if (w_div_ovf) begin
      w_sq = 32'sh8000_0000;
      w_sr = 32'sd0;
    end else begin
      w_sq = w_sa / w_sb;
      w_sr = w_sa % w_sb;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, commit on last cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_cnt_load;
        end
      end
      S_BUSY: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // HI/LO update: op result at commit, else mthi/mtlo when idle and not starting
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (w_commit) begin
      case (r_op)
        OP_MULTU: begin
          w_hi_nxt = w_umul[63:32];
          w_lo_nxt = w_umul[31:0];
        end
        OP_MULT: begin
          w_hi_nxt = w_smul[63:32];
          w_lo_nxt = w_smul[31:0];
        end
        OP_DIVU: begin
          if (!w_div_zero) begin
            w_hi_nxt = w_ur;
            w_lo_nxt = w_uq;
          end
        end
        OP_DIV: begin
          if (!w_div_zero) begin
            w_hi_nxt = w_sr;
            w_lo_nxt = w_sq;
          end
        end
        default: ;
      endcase
    end else if ((r_state == S_IDLE) && MDWE && !start) begin
      if (MDAddrOp) w_hi_nxt = A;
      else          w_lo_nxt = A;
    end
  end

  // State, counter, busy flag and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_BUSY);
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // Operand capture at acceptance; later A/B changes do not reach the datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (start) begin
      r_op <= MDOp;
      r_a  <= A;
      r_b  <= B;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu. Expected HI/LO pairs come from a
// 64-bit integer model and are queued when an op is accepted.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  MDOp = '0;
  logic        MDWE = 1'b0;
  logic        MDAddrOp = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        start, busy;
  logic [31:0] MDOut;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [31:0] hi; logic [31:0] lo; } res_t;
  res_t sb[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .MDWE(MDWE), .MDAddrOp(MDAddrOp),
    .A(A), .B(B), .start(start), .busy(busy), .MDOut(MDOut)
  );

  always #10 clk = ~clk;

  function automatic res_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] hi,
                                 input logic [31:0] lo);
    longint unsigned ua, ub, up;
    longint sa, sb_, sp, q, r;
    res_t o;
    o.hi = hi; o.lo = lo;
    ua = a; ub = b;
    sa = $signed(a); sb_ = $signed(b);
    case (op)
      3'd1: begin up = ua * ub; o.hi = up[63:32]; o.lo = up[31:0]; end
      3'd2: begin sp = sa * sb_; o.hi = sp[63:32]; o.lo = sp[31:0]; end
      3'd3: if (b != 0) begin up = ua / ub; o.lo = up[31:0]; up = ua % ub; o.hi = up[31:0]; end
      3'd4: if (b != 0) begin q = sa / sb_; r = sa % sb_; o.lo = q[31:0]; o.hi = r[31:0]; end
      default: ;
    endcase
    return o;
  endfunction

  // Drive an op (caller sits in the low phase); queue its expected result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic st);
    res_t e;
    MDOp = op; A = a; B = b;
    #1 st = start;
    if (st === 1'b1) begin
      e = model(op, a, b, m_hi, m_lo);
      sb.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
    end
    @(posedge clk); #1;
    MDOp = '0; MDWE = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  // Count busy cycles until busy drops, bounded.
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MDAddrOp = 1'b1; #1 hi = MDOut;
    MDAddrOp = 1'b0; #1 lo = MDOut;
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    MDOp = 3'b010; A = 32'd5; B = 32'd6;
    #3;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    read_hilo(h, l);
    checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL rst_hilo got %h/%h exp 0/0", h, l); end
    @(negedge clk); @(negedge clk);
    MDOp = '0;
    reset = 1'b1;
  endtask

  task automatic test_mult();
    logic st; int n; logic [31:0] h, l; res_t e;
    issue(3'b010, 32'hFFFF_FFFE, 32'd3, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_start got %b exp 1", st); end
    wait_done(n);
    checks++; if (n != MC) begin errors++; $display("FAIL mult_busy got %0d exp %0d", n, MC); end
    read_hilo(h, l); e = sb.pop_front();
    checks++; if (h !== e.hi || l !== e.lo) begin errors++; $display("FAIL mult_res got %h/%h exp %h/%h", h, l, e.hi, e.lo); end
    checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_const got %h/%h exp ffffffff/fffffffa", h, l); end
    issue(3'b001, 32'hFFFF_FFFE, 32'd3, st);
    wait_done(n);
    read_hilo(h, l); e = sb.pop_front();
    checks++; if (h !== e.hi || l !== e.lo) begin errors++; $display("FAIL multu_res got %h/%h exp %h/%h", h, l, e.hi, e.lo); end
    checks++; if (h !== 32'h0000_0002 || l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_const got %h/%h exp 00000002/fffffffa", h, l); end
  endtask

  task automatic test_div();
    logic st; int n; logic [31:0] h, l; res_t e;
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, st);
    wait_done(n);
    checks++; if (n != DC) begin errors++; $display("FAIL div_busy got %0d exp %0d", n, DC); end
    read_hilo(h, l); e = sb.pop_front();
    checks++; if (h !== e.hi || l !== e.lo) begin errors++; $display("FAIL div_res got %h/%h exp %h/%h", h, l, e.hi, e.lo); end
    checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_const got %h/%h exp ffffffff/fffffffd", h, l); end
    issue(3'b011, 32'd7, 32'd0, st);
    wait_done(n);
    checks++; if (n != DC) begin errors++; $display("FAIL divu0_busy got %0d exp %0d", n, DC); end
    read_hilo(h, l); e = sb.pop_front();
    checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD || h !== e.hi || l !== e.lo) begin errors++; $display("FAIL divu0_keep got %h/%h exp %h/%h", h, l, e.hi, e.lo); end
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, st);
    wait_done(n);
    read_hilo(h, l); e = sb.pop_front();
    checks++; if (h !== 32'd0 || l !== 32'h8000_0000 || h !== e.hi || l !== e.lo) begin errors++; $display("FAIL div_ovf got %h/%h exp 00000000/80000000", h, l); end
  endtask

  task automatic test_random();
    logic st; int n; logic [31:0] h, l, a, b; logic [2:0] op; res_t e;
    for (int i = 0; i < 8; i++) begin
      op = 3'(1 + (i % 4)); a = $urandom; b = $urandom;
      if (i == 5) b = 32'hFFFF_FFF0;
      issue(op, a, b, st);
      wait_done(n);
      read_hilo(h, l); e = sb.pop_front();
      checks++; if (h !== e.hi || l !== e.lo || n != ((op <= 3'd2) ? MC : DC)) begin errors++; $display("FAIL rand_%0d op %0d got %h/%h n %0d exp %h/%h", i, op, h, l, n, e.hi, e.lo); end
    end
  endtask

  task automatic test_mthi();
    logic st; int n; logic [31:0] h, l, ph; res_t e;
    ph = m_hi;
    issue(3'b001, 32'h1000, 32'h10, st);
    @(negedge clk);
    MDWE = 1'b1; MDAddrOp = 1'b1; A = 32'h1234_5678; MDOp = 3'b100;
    #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL busy_start got %b exp 0", start); end
    checks++; if (MDOut !== ph) begin errors++; $display("FAIL busy_hi got %h exp %h", MDOut, ph); end
    @(negedge clk);
    MDWE = 1'b0; MDOp = '0;
    wait_done(n);
    checks++; if (n + 2 != MC) begin errors++; $display("FAIL mthi_busy got %0d exp %0d", n + 2, MC); end
    read_hilo(h, l); e = sb.pop_front();
    checks++; if (h !== e.hi || l !== e.lo) begin errors++; $display("FAIL busy_mthi_ign got %h/%h exp %h/%h", h, l, e.hi, e.lo); end
    MDWE = 1'b1; MDAddrOp = 1'b1; A = 32'h1234_5678;
    @(posedge clk); #1 MDWE = 1'b0; A = 32'h0;
    @(negedge clk);
    read_hilo(h, l); m_hi = 32'h1234_5678;
    checks++; if (h !== 32'h1234_5678 || l !== m_lo) begin errors++; $display("FAIL mthi got %h/%h exp 12345678/%h", h, l, m_lo); end
    MDWE = 1'b1; MDAddrOp = 1'b0; A = 32'hA5A5_0F0F;
    @(posedge clk); #1 MDWE = 1'b0;
    @(negedge clk);
    read_hilo(h, l); m_lo = 32'hA5A5_0F0F;
    checks++; if (h !== m_hi || l !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mtlo got %h/%h exp %h/a5a50f0f", h, l, m_hi); end
  endtask

  task automatic test_precedence();
    logic st; int n; logic [31:0] h, l, ph; res_t e;
    ph = m_hi;
    MDWE = 1'b1; MDAddrOp = 1'b1;
    issue(3'b010, 32'hCAFE_0001, 32'd2, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL prec_start got %b exp 1", st); end
    @(negedge clk);
    MDAddrOp = 1'b1; #1;
    checks++; if (MDOut !== ph) begin errors++; $display("FAIL prec_hi got %h exp %h", MDOut, ph); end
    wait_done(n);
    read_hilo(h, l); e = sb.pop_front();
    checks++; if (h !== e.hi || l !== e.lo || n + 1 != MC) begin errors++; $display("FAIL prec_res got %h/%h n %0d exp %h/%h", h, l, n + 1, e.hi, e.lo); end
  endtask

  task automatic test_reset_abort();
    logic st; int n; logic [31:0] h, l; res_t e;
    issue(3'b100, 32'd100, 32'd7, st);
    @(negedge clk); @(negedge clk); @(negedge clk);
    MDOp = 3'b010;
    #1 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL abort_busy got busy %b start %b exp 0 0", busy, start); end
    read_hilo(h, l);
    checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL abort_hilo got %h/%h exp 0/0", h, l); end
    sb.delete(); m_hi = '0; m_lo = '0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    MDOp = '0;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    read_hilo(h, l);
    checks++; if (h !== 32'd0 || l !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_nocommit got %h/%h busy %b exp 0/0 0", h, l, busy); end
    issue(3'b010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, st);
    wait_done(n);
    read_hilo(h, l); e = sb.pop_front();
    checks++; if (h !== e.hi || l !== e.lo || n != MC || st !== 1'b1) begin errors++; $display("FAIL post_rst got %h/%h n %0d exp %h/%h", h, l, n, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back();
    logic st; int n; logic [31:0] h, l; res_t e1, e2;
    issue(3'b010, 32'd123456, 32'hFFFF_FCEB, st);
    wait_done(n);
    read_hilo(h, l); e1 = sb.pop_front();
    checks++; if (h !== e1.hi || l !== e1.lo) begin errors++; $display("FAIL b2b_first got %h/%h exp %h/%h", h, l, e1.hi, e1.lo); end
    issue(3'b010, 32'h0001_0001, 32'h0002_0003, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL b2b_start got %b exp 1", st); end
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      read_hilo(h, l);
      checks++; if (h !== e1.hi || l !== e1.lo) begin errors++; $display("FAIL b2b_hold got %h/%h exp %h/%h", h, l, e1.hi, e1.lo); end
      n++;
      @(negedge clk);
    end
    checks++; if (n != MC) begin errors++; $display("FAIL b2b_busy got %0d exp %0d", n, MC); end
    read_hilo(h, l); e2 = sb.pop_front();
    checks++; if (h !== e2.hi || l !== e2.lo) begin errors++; $display("FAIL b2b_second got %h/%h exp %h/%h", h, l, e2.hi, e2.lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_mthi();
    test_precedence();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port MDOp  input  3  operation: 001 multu, 010 mult, 011 divu, 100 div; 000, 101-111 no operation.
REQ-007 SHALL have port MDWE  input  1  write A into HI or LO (mthi/mtlo).
REQ-008 SHALL have port MDAddrOp  input  1  register select for read and write: 1 HI, 0 LO.
REQ-009 SHALL have port A  input  32  rs operand (dividend, multiplicand, mthi/mtlo data).
REQ-010 SHALL have port B  input  32  rt operand (divisor, multiplier).
REQ-011 SHALL have port start  output  1  combinational; 1 while an operation is being accepted this cycle.
REQ-012 SHALL have port busy  output  1  registered; 1 while an accepted operation is in progress.
REQ-013 SHALL have port MDOut  output  32  combinational; HI if MDAddrOp=1, else LO (mfhi/mflo).

Function
REQ-014 SHALL implement states IDLE and BUSY, plus a down-counter of at least 4 bits.
REQ-015 SHALL drive start=1 exactly when state is IDLE and MDOp is 001-100.
REQ-016 SHALL, at a clock edge with start=1, enter BUSY, load counter with MULT_CYCLES or DIV_CYCLES, and capture MDOp, A and B.
REQ-017 SHALL keep busy=1 for exactly N cycles after the accepting edge (N = loaded count).
REQ-018 SHALL write HI and LO at the edge ending the Nth busy cycle, then return to IDLE with busy=0.
REQ-019 SHALL make the new HI/LO visible on MDOut in the cycle after busy falls.
REQ-020 SHALL compute multu as unsigned 64-bit A*B and mult as signed 64-bit A*B, with HI = bits 63:32 and LO = bits 31:0.
REQ-021 SHALL compute divu as unsigned division, with LO = quotient and HI = remainder.
REQ-022 SHALL compute div as signed division, with the quotient truncated toward zero and the remainder taking the dividend's sign.
REQ-023 SHALL, for div with 0x80000000 / 0xFFFFFFFF, give LO=0x80000000 and HI=0.
REQ-024 SHALL, for divisor 0 (div or divu), still run the full busy period, and SHALL leave HI and LO unchanged.
REQ-025 SHALL, when IDLE with MDWE=1 and start=0, write A into HI (MDAddrOp=1) or LO (MDAddrOp=0) at the clock edge.
REQ-026 SHALL give MDOp precedence when MDOp is valid and MDWE=1 in the same IDLE cycle, and SHALL discard the MDWE write.
REQ-027 SHALL ignore MDOp and MDWE while BUSY; it SHALL keep start=0, accept no operation and make no register write.
REQ-028 SHALL make MDOut show the pre-operation HI/LO while BUSY.
REQ-029 SHALL allow back-to-back operations, so that a valid MDOp in the first IDLE cycle after busy falls is accepted.
REQ-030 SHALL compute results from the captured operands only; changes to A/B after acceptance SHALL have no effect.

Reset
REQ-031 SHALL, while reset=0, force state IDLE, counter 0, busy=0 and HI=LO=0 immediately, without waiting for clk.
REQ-032 SHALL abort any in-progress operation on reset assertion, with no HI/LO commit afterwards.
REQ-033 SHALL hold start=0 while reset=0.
REQ-034 SHALL start in IDLE and accept a valid MDOp at the first rising edge after reset deasserts.

Verification
REQ-035 SHALL be checked with: mult, A=0xFFFFFFFE (-2), B=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-036 SHALL be checked with: div, A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu, A=7, B=0 -> busy for 10 cycles, HI/LO unchanged.
REQ-037 SHALL be checked with: mthi, A=0x12345678, while BUSY -> ignored, start=0; the same mthi while IDLE -> MDOut=0x12345678 with MDAddrOp=1 in the next cycle.
REQ-038 SHALL be checked with: MDOp=010 and MDWE=1 in the same IDLE cycle -> mult accepted, MDWE write discarded.
REQ-039 SHALL be checked with: reset=0 asserted in busy cycle 3 of a div -> busy=0 and HI=LO=0 immediately, and a mult issued after release completes normally.
REQ-040 SHALL be checked with: a second mult issued in the cycle after busy falls -> start=1 and busy again for 5 cycles; MDOut during that period equals the first result.
